// File: rtl/deser_lane_arbiter_pkg.sv
// deser_arb_pkg: FSM state type and width helpers shared by deser_lane_arbiter.
// Optional watchdog build: DESER_ARB_TIMEOUT_EN.
package deser_arb_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int width);
        return clog2_min1(width);
    endfunction
    localparam int LANE_W = clog2_min1(4);
endpackage

// File: rtl/deser_lane_arbiter_if.sv
// deser_lane_arbiter_if: lane-side serial signals and word-side outputs of the arbiter.
// timeout_o exists only when DESER_ARB_TIMEOUT_EN is defined.
interface deser_lane_arbiter_if #(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 16
);
    import deser_arb_pkg::*;
    localparam int LW = clog2_min1(N_LANES);
    logic [N_LANES-1:0] lane_req_i;
    logic [N_LANES-1:0] lane_data_i;
    logic [N_LANES-1:0] lane_val_i;
    logic [N_LANES-1:0] lane_gnt_o;
    logic [WIDTH-1:0]   deser_data_o;
    logic               deser_data_val_o;
    logic [LW-1:0]      deser_lane_o;
    logic               busy_o;
`ifdef DESER_ARB_TIMEOUT_EN
    logic               timeout_o;
    modport master (output lane_req_i, lane_data_i, lane_val_i,
                    input lane_gnt_o, deser_data_o, deser_data_val_o, deser_lane_o, busy_o, timeout_o);
    modport slave (input lane_req_i, lane_data_i, lane_val_i,
                   output lane_gnt_o, deser_data_o, deser_data_val_o, deser_lane_o, busy_o, timeout_o);
`else
    modport master (output lane_req_i, lane_data_i, lane_val_i,
                    input lane_gnt_o, deser_data_o, deser_data_val_o, deser_lane_o, busy_o);
    modport slave (input lane_req_i, lane_data_i, lane_val_i,
                   output lane_gnt_o, deser_data_o, deser_data_val_o, deser_lane_o, busy_o);
`endif
endinterface

// File: rtl/deser_lane_arbiter_shift_core.sv
// deser_shift_core: shared serial-to-parallel engine with bit counter; o_done marks the
// cycle the final bit is presented, when o_data already shows the complete word.
module deser_shift_core
    import deser_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_bit,
    input  logic             i_bit_val,
    output logic [WIDTH-1:0] o_data,
    output logic             o_done
);
    localparam int CW = cnt_w(WIDTH);
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_sr;
    // The incoming bit forms the LSB, so the final bit completes the word without an extra cycle.
    assign o_data = {r_sr, i_bit};
    assign o_done = i_bit_val && (r_cnt == CW'(WIDTH - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (i_bit_val) begin
            r_cnt <= o_done ? '0 : r_cnt + 1'b1;
            r_sr  <= o_data[WIDTH-2:0];
        end
    end
endmodule

// File: rtl/deser_lane_arbiter.sv
// deser_lane_arbiter: round-robin grant of one shared deserializer to N_LANES serial lanes,
// one frame per grant. Define DESER_ARB_TIMEOUT_EN to add the idle-bit watchdog and timeout_o.
module deser_lane_arbiter
    import deser_arb_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int WIDTH   = 16
`ifdef DESER_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input logic                 clk_i,
    input logic                 arst_n_i,
    deser_lane_arbiter_if.slave bus
);
    localparam int LW = clog2_min1(N_LANES);
    state_t             r_state, w_next;
    logic [N_LANES-1:0] r_gnt, w_hi;
    logic [LW-1:0]      r_cur, r_ptr, r_lane, w_sel, w_lo, w_hi_idx;
    logic [WIDTH-1:0]   r_data, w_word;
    logic               r_dval, w_bit, w_val, w_done, w_end;
    assign w_bit = |(bus.lane_data_i & r_gnt);
    assign w_val = (r_state == SHIFT) && |(bus.lane_val_i & r_gnt);
    // Requests at or above the pointer win; otherwise wrap to the lowest requester.
    assign w_hi  = bus.lane_req_i & ~((N_LANES'(1) << r_ptr) - N_LANES'(1));
    always_comb begin
        w_lo     = '0;
        w_hi_idx = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (bus.lane_req_i[i]) w_lo = LW'(i);
            if (w_hi[i]) w_hi_idx = LW'(i);
        end
        w_sel = |w_hi ? w_hi_idx : w_lo;
    end
    deser_shift_core #(.WIDTH(WIDTH)) u_core (
        .i_clk     (clk_i),
        .i_rst_n   (arst_n_i),
        .i_clear   (r_state == IDLE),
        .i_bit     (w_bit),
        .i_bit_val (w_val),
        .o_data    (w_word),
        .o_done    (w_done)
    );
`ifdef DESER_ARB_TIMEOUT_EN
    localparam int WDW = clog2_min1(TIMEOUT);
    logic [WDW-1:0] r_wd;
    logic           r_to, w_to;
    assign w_to  = (r_state == SHIFT) && !w_val && (r_wd == WDW'(TIMEOUT - 1));
    assign w_end = w_done || w_to;
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wd <= '0;
            r_to <= 1'b0;
        end else begin
            r_wd <= (r_state != SHIFT || w_val || w_to) ? '0 : r_wd + 1'b1;
            r_to <= w_to;
        end
    end
    assign bus.timeout_o = r_to;
`else
    assign w_end = w_done;
`endif
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (|bus.lane_req_i ? SHIFT : IDLE) : (w_end ? IDLE : SHIFT);
    end
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_gnt  <= '0;
            r_cur  <= '0;
            r_ptr  <= '0;
            r_data <= '0;
            r_lane <= '0;
            r_dval <= 1'b0;
        end else begin
            r_dval <= w_done;
            if (r_state == IDLE && |bus.lane_req_i) begin
                r_gnt <= N_LANES'(1) << w_sel;
                r_cur <= w_sel;
            end else if (w_end) begin
                r_gnt <= '0;
                r_ptr <= (r_cur == LW'(N_LANES - 1)) ? '0 : r_cur + 1'b1;
            end
            if (w_done) begin
                r_data <= w_word;
                r_lane <= r_cur;
            end
        end
    end
    always_comb begin
        bus.lane_gnt_o       = r_gnt;
        bus.busy_o           = (r_state == SHIFT);
        bus.deser_data_o     = r_data;
        bus.deser_data_val_o = r_dval;
        bus.deser_lane_o     = r_lane;
    end
endmodule
